id_exe_stage_reg: RTL and testbench



---
 rtl/id_exe_stage_reg_if.sv | 50 +++++
 rtl/id_exe_stage_reg.sv | 105 ++++++++++
 tb/tb_id_exe_stage_reg.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/id_exe_stage_reg_if.sv
// ID -> EXE pipeline bundle: ID-side inputs, EXE-side registered outputs,
// plus the pipeline control strobes (freeze/flush/hazard).
interface id_exe_stage_reg_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  freeze;
   logic                  flush;
   logic                  hazard;
   logic                  valid_in;
   logic                  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
   logic [3:0]            exe_cmd_in;
   logic [DATA_WIDTH-1:0] pc_in, val_rn_in, val_rm_in;
   logic                  imm_in;
   logic [11:0]           shift_operand_in;
   logic [23:0]           signed_imm_24_in;
   logic [3:0]            dest_in, src1_in, src2_in, sr_in;

   logic                  valid_out;
   logic                  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
   logic [3:0]            exe_cmd_out;
   logic [DATA_WIDTH-1:0] pc_out, val_rn_out, val_rm_out;
   logic                  imm_out;
   logic [11:0]           shift_operand_out;
   logic [23:0]           signed_imm_24_out;
   logic [3:0]            dest_out, src1_out, src2_out, sr_out;
   logic [CNT_WIDTH-1:0]  bubble_count;

   modport master (
      output freeze, flush, hazard, valid_in,
      output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
      output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
      output signed_imm_24_in, dest_in, src1_in, src2_in, sr_in,
      input  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
      input  exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
      input  shift_operand_out, signed_imm_24_out, dest_out, src1_out,
      input  src2_out, sr_out, bubble_count
   );

   modport slave (
      input  freeze, flush, hazard, valid_in,
      input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
      input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
      input  signed_imm_24_in, dest_in, src1_in, src2_in, sr_in,
      output valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
      output exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
      output shift_operand_out, signed_imm_24_out, dest_out, src1_out,
      output src2_out, sr_out, bubble_count
   );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with flush/hazard bubble insertion, global freeze,
// valid tracking and a saturating bubble counter.
module id_exe_stage_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic               clk,
   input  logic               rst,
   id_exe_stage_reg_if.slave  bus
);
   typedef struct packed {
      logic                  wb_en;
      logic                  mem_r_en;
      logic                  mem_w_en;
      logic                  b;
      logic                  s;
      logic [3:0]            exe_cmd;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] val_rn;
      logic [DATA_WIDTH-1:0] val_rm;
      logic                  imm;
      logic [11:0]           shift_operand;
      logic [23:0]           signed_imm_24;
      logic [3:0]            dest;
      logic [3:0]            src1;
      logic [3:0]            src2;
      logic [3:0]            sr;
   } fields_t;

   fields_t               fields_reg, fields_next, fields_in;
   logic                  valid_reg, valid_next;
   logic [CNT_WIDTH-1:0]  count_reg, count_next;

   assign fields_in = '{
      wb_en:         bus.wb_en_in,
      mem_r_en:      bus.mem_r_en_in,
      mem_w_en:      bus.mem_w_en_in,
      b:             bus.b_in,
      s:             bus.s_in,
      exe_cmd:       bus.exe_cmd_in,
      pc:            bus.pc_in,
      val_rn:        bus.val_rn_in,
      val_rm:        bus.val_rm_in,
      imm:           bus.imm_in,
      shift_operand: bus.shift_operand_in,
      signed_imm_24: bus.signed_imm_24_in,
      dest:          bus.dest_in,
      src1:          bus.src1_in,
      src2:          bus.src2_in,
      sr:            bus.sr_in
   };

   // An all-zero field set is a NOP: no write-back, no memory access, so a
   // bubble can never re-arm the hazard unit.
   always_comb begin
      fields_next = fields_reg;
      valid_next  = valid_reg;
      count_next  = count_reg;
      if (!bus.freeze) begin
         if (bus.flush) begin
            fields_next = '0;
            valid_next  = 1'b0;
         end else if (bus.hazard) begin
            fields_next = '0;
            valid_next  = 1'b0;
            if (count_reg != {CNT_WIDTH{1'b1}})
               count_next = count_reg + 1'b1;
         end else begin
            fields_next = fields_in;
            valid_next  = bus.valid_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fields_reg <= '0;
         valid_reg  <= 1'b0;
         count_reg  <= '0;
      end else begin
         fields_reg <= fields_next;
         valid_reg  <= valid_next;
         count_reg  <= count_next;
      end
   end

   assign bus.wb_en_out         = fields_reg.wb_en;
   assign bus.mem_r_en_out      = fields_reg.mem_r_en;
   assign bus.mem_w_en_out      = fields_reg.mem_w_en;
   assign bus.b_out             = fields_reg.b;
   assign bus.s_out             = fields_reg.s;
   assign bus.exe_cmd_out       = fields_reg.exe_cmd;
   assign bus.pc_out            = fields_reg.pc;
   assign bus.val_rn_out        = fields_reg.val_rn;
   assign bus.val_rm_out        = fields_reg.val_rm;
   assign bus.imm_out           = fields_reg.imm;
   assign bus.shift_operand_out = fields_reg.shift_operand;
   assign bus.signed_imm_24_out = fields_reg.signed_imm_24;
   assign bus.dest_out          = fields_reg.dest;
   assign bus.src1_out          = fields_reg.src1;
   assign bus.src2_out          = fields_reg.src2;
   assign bus.sr_out            = fields_reg.sr;
   assign bus.valid_out         = valid_reg;
   assign bus.bubble_count      = count_reg;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: directed vectors push hand-computed
// expectations, a monitor pops and compares one per clock edge.
module tb_id_exe_stage_reg;
   localparam int DW = 32;
   localparam int CW = 4;

   typedef struct packed {
      logic        wb_en, mem_r_en, mem_w_en, b, s;
      logic [3:0]  exe_cmd;
      logic [31:0] pc, val_rn, val_rm;
      logic        imm;
      logic [11:0] shift_operand;
      logic [23:0] signed_imm_24;
      logic [3:0]  dest, src1, src2, sr;
   } fld_t;

   typedef struct packed {
      fld_t        f;
      logic        valid;
      logic [3:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_exe_stage_reg_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   id_exe_stage_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   function automatic exp_t mk(input fld_t f, input logic v, input logic [3:0] c);
      exp_t e;
      e.f = f; e.valid = v; e.cnt = c;
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t e;
      e.f = '{bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.b_out,
              bus.s_out, bus.exe_cmd_out, bus.pc_out, bus.val_rn_out,
              bus.val_rm_out, bus.imm_out, bus.shift_operand_out,
              bus.signed_imm_24_out, bus.dest_out, bus.src1_out,
              bus.src2_out, bus.sr_out};
      e.valid = bus.valid_out;
      e.cnt   = bus.bubble_count;
      return e;
   endfunction

   // Drive one cycle of stimulus (at negedge) and queue what the next edge must produce.
   task automatic apply(input fld_t f, input logic v, input logic r, input logic frz,
                        input logic fl, input logic hz, input exp_t e);
      @(negedge clk);
      rst = r; bus.freeze = frz; bus.flush = fl; bus.hazard = hz; bus.valid_in = v;
      bus.wb_en_in = f.wb_en; bus.mem_r_en_in = f.mem_r_en; bus.mem_w_en_in = f.mem_w_en;
      bus.b_in = f.b; bus.s_in = f.s; bus.exe_cmd_in = f.exe_cmd; bus.pc_in = f.pc;
      bus.val_rn_in = f.val_rn; bus.val_rm_in = f.val_rm; bus.imm_in = f.imm;
      bus.shift_operand_in = f.shift_operand; bus.signed_imm_24_in = f.signed_imm_24;
      bus.dest_in = f.dest; bus.src1_in = f.src1; bus.src2_in = f.src2; bus.sr_in = f.sr;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are presented every edge; compare #1 after it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t want, got;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            txn++;
            if (got !== want) begin
               errors++;
               $display("FAIL txn%0d outputs: got valid=%0b cnt=%0d f=%h, want valid=%0b cnt=%0d f=%h",
                        txn, got.valid, got.cnt, got.f, want.valid, want.cnt, want.f);
            end else begin
               $display("txn%0d ok valid=%0b cnt=%0d dest=%0d pc=%h",
                        txn, got.valid, got.cnt, got.f.dest, got.f.pc);
            end
         end
      end
   end

   fld_t z, all1, va, vb, vc, vd, ve;

   initial begin
      z = '0;
      all1 = '1;
      va = '0; va.pc = 32'h10; va.dest = 4'd5; va.wb_en = 1'b1; va.exe_cmd = 4'b0010;
      vb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 32'h0000_0020, 32'hDEAD_BEEF,
             32'h1234_5678, 1'b1, 12'hABC, 24'h00_1234, 4'd3, 4'd1, 4'd2, 4'b1010};
      vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 32'h0000_0100, 32'h0000_0001,
             32'h8000_0000, 1'b0, 12'h00F, 24'hFF_FFFE, 4'd14, 4'd8, 4'd9, 4'b0100};
      vd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 32'h0000_0200, 32'hCAFE_F00D,
             32'h0000_0042, 1'b1, 12'h123, 24'h12_3456, 4'd6, 4'd4, 4'd5, 4'b0001};
      ve = '0; ve.dest = 4'd7; ve.pc = 32'h44; ve.wb_en = 1'b1;
      rst = 1'b1;
      bus.freeze = 1'b0; bus.flush = 1'b0; bus.hazard = 1'b0; bus.valid_in = 1'b0;

      // Reset with every input high (freeze stays low so reset alone is tested).
      apply(all1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, mk(z, 1'b0, 4'd0));
      apply(all1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, mk(z, 1'b0, 4'd0));
      // Normal load.
      apply(va, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(va, 1'b1, 4'd0));
      // Three hazard bubbles: cleared NOP, counter 1,2,3.
      apply(vb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(z, 1'b0, 4'd1));
      apply(vb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(z, 1'b0, 4'd2));
      apply(vb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(z, 1'b0, 4'd3));
      apply(vb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(vb, 1'b1, 4'd3));
      // Flush beats hazard: cleared, counter unchanged.
      apply(vc, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mk(z, 1'b0, 4'd3));
      apply(vc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(vc, 1'b1, 4'd3));
      // Freeze beats flush and hazard: everything holds.
      apply(vd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mk(vc, 1'b1, 4'd3));
      apply(vd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mk(z, 1'b0, 4'd3));
      apply(vd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(z, 1'b0, 4'd3));
      // Load with valid_in low: fields pass through, valid_out stays 0.
      apply(vd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(vd, 1'b0, 4'd3));
      // 20 hazards with valid_in low: counter climbs 4..15 then sticks at 15.
      for (int i = 1; i <= 20; i++)
         apply(vb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               mk(z, 1'b0, (3 + i > 15) ? 4'd15 : 4'(3 + i)));
      apply(ve, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(ve, 1'b1, 4'd15));
      // Reset while frozen: reset wins.
      apply(vd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(z, 1'b0, 4'd0));
      // First edge after reset loads normally.
      apply(va, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(va, 1'b1, 4'd0));

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
